// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for product_accumulator: FSM state encoding,
// default widths and the saturation limits used when SATURATE_EN is defined.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PROD_W_DEF     = 16;
  localparam int ACC_W_DEF      = 20;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LEN_W          = 8;

  // Two's-complement limits of a w-bit signed value.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [63:0] SAT_MAX_DEF = sat_max(ACC_W_DEF);
  localparam logic signed [63:0] SAT_MIN_DEF = sat_min(ACC_W_DEF);

endpackage

// File: rtl/prod_fifo.sv
// Small FIFO buffering products between the multiplier and the accumulator.
// A push into a full FIFO still succeeds when a pop happens in the same cycle.
module prod_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a run of len signed products from a buffered input stream.
// Define SATURATE_EN to clamp overflowing sums instead of wrapping.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W     = PROD_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     busy,
  output logic                     ovf,
  output logic                     drop
);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                     ovf_q, ovf_d;
  logic                     drop_q, drop_d;

  logic                     push, pop, full, empty;
  logic [PROD_W-1:0]        fifo_data;

  logic signed [ACC_W:0]    acc_ext, prod_ext, sum_ext;
  logic                     sum_ovf;
  logic signed [ACC_W-1:0]  sum_res;

  prod_fifo #(
    .W     (PROD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (prod_in),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (empty)
  );

  // One guard bit above ACC_W exposes overflow as a mismatch of the top two bits.
  assign acc_ext  = {acc_q[ACC_W-1], acc_q};
  assign prod_ext = {{(ACC_W+1-PROD_W){fifo_data[PROD_W-1]}}, fifo_data};
  assign sum_ext  = acc_ext + prod_ext;
  assign sum_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign cnt_inc  = cnt_q + 1'b1;

`ifdef SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
  assign sum_res = !sum_ovf ? sum_ext[ACC_W-1:0] : (sum_ext[ACC_W] ? SAT_MIN : SAT_MAX);
`else
  assign sum_res = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = (len == '0) ? LEN_W'(1) : len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!empty) begin
          pop   = 1'b1;
          acc_d = sum_res;
          cnt_d = cnt_inc;
          if (sum_ovf) ovf_d = 1'b1;
          if (cnt_inc == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (acc_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Input side runs in every state so products queue up for the next sum.
    push = prod_valid && (!full || pop);
    if (prod_valid && full && !pop) drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign prod_ready = !full;
  assign acc_out    = acc_q;
  assign acc_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign ovf        = ovf_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with hand-computed sums.
module tb_product_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] prod_in;
  logic               prod_valid;
  logic               prod_ready;
  logic               start;
  logic [7:0]         len;
  logic signed [19:0] acc_out;
  logic               acc_valid;
  logic               acc_ready;
  logic               busy;
  logic               ovf;
  logic               drop;

  int n_chk = 0;
  int n_err = 0;

  product_accumulator #(
    .PROD_W     (16),
    .ACC_W      (20),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .start      (start),
    .len        (len),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .busy       (busy),
    .ovf        (ovf),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [15:0] v);
    prod_in    = v;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic begin_sum(input logic [7:0] n);
    len   = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!acc_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(acc_valid), 1);
  endtask

  task automatic accept();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    logic stable;
    rst        = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    start      = 1'b0;
    len        = '0;
    acc_ready  = 1'b0;
    #1;
    check("rst_acc_out",    32'(acc_out),    0);
    check("rst_acc_valid",  32'(acc_valid),  0);
    check("rst_busy",       32'(busy),       0);
    check("rst_ovf",        32'(ovf),        0);
    check("rst_drop",       32'(drop),       0);
    check("rst_prod_ready", 32'(prod_ready), 1);
    tick();
    rst = 1'b0;
    tick();

    // len=3: 660 - 128 + 1000
    begin_sum(8'd3);
    check("s1_busy", 32'(busy), 1);
    push(16'sd660);
    push(-16'sd128);
    push(16'sd1000);
    check("s1_valid_early", 32'(acc_valid), 0);
    tick();
    check("s1_valid_after_pop", 32'(acc_valid), 1);
    check("s1_acc",  32'(acc_out), 1532);
    check("s1_ovf",  32'(ovf), 0);
    accept();
    check("s1_idle", 32'(busy), 0);

    // five strobes while idle: fifth is dropped
    push(16'sd10);
    push(16'sd20);
    push(16'sd30);
    check("fill3_ready", 32'(prod_ready), 1);
    push(16'sd40);
    check("full_ready", 32'(prod_ready), 0);
    check("full_drop",  32'(drop), 0);
    push(16'sd50);
    check("drop_set",   32'(drop), 1);
    begin_sum(8'd4);
    check("drop_clr",   32'(drop), 0);
    wait_valid("s2");
    check("s2_acc", 32'(acc_out), 100);
    accept();

    // len=0 behaves as len=1
    begin_sum(8'd0);
    push(-16'sd42);
    check("s3_valid_early", 32'(acc_valid), 0);
    tick();
    check("s3_valid", 32'(acc_valid), 1);
    check("s3_acc",   32'(acc_out), -42);

    // hold result ten cycles while two products arrive
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      push(16'sd7);
      else if (i == 5) push(16'sd8);
      else             tick();
      if (acc_out !== -20'sd42 || acc_valid !== 1'b1) stable = 1'b0;
    end
    check("s3_hold", 32'(stable), 1);
    accept();
    begin_sum(8'd2);
    wait_valid("s4");
    check("s4_acc", 32'(acc_out), 15);
    accept();

    // 17 x 32767 overflows a 20-bit accumulator
    begin_sum(8'd17);
    for (int i = 0; i < 17; i++) push(16'sd32767);
    wait_valid("s5");
    check("s5_ovf", 32'(ovf), 1);
`ifdef SATURATE_EN
    check("s5_acc", 32'(acc_out), 524287);
`else
    check("s5_acc", 32'(acc_out), -491537);
`endif
    accept();

    // reset in the middle of a len=5 sum
    begin_sum(8'd5);
    check("s6_ovf_clr", 32'(ovf), 0);
    push(16'sd1);
    push(16'sd2);
    push(16'sd3);
    check("s6_partial", 32'(acc_out), 3);
    rst = 1'b1;
    #1;
    check("mid_rst_acc_out",    32'(acc_out),    0);
    check("mid_rst_acc_valid",  32'(acc_valid),  0);
    check("mid_rst_busy",       32'(busy),       0);
    check("mid_rst_ovf",        32'(ovf),        0);
    check("mid_rst_prod_ready", 32'(prod_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    begin_sum(8'd1);
    tick();
    tick();
    tick();
    check("s7_flushed", 32'(acc_valid), 0);
    push(16'sd9);
    wait_valid("s7");
    check("s7_acc", 32'(acc_out), 9);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
